fifo_rd_sched: RTL and testbench

Round-robin scheduler that shares the async FIFO read port among NREQ consumers in the read clock domain. It sits between the FIFO read-side controller (pop/empty) and the consumers, and grants bursts of up to BURST pops per requester. It drives the single pop line and tags each popped word with the consumer it belongs to.

---
 rtl/fifo_sched_pkg.sv | 27 ++
 rtl/rr_pick.sv | 26 ++
 rtl/fifo_rd_sched.sv | 122 ++++++++++++
 tb/tb_fifo_rd_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared state encoding and helpers for the FIFO read-port scheduler.
// Optional behaviour in fifo_rd_sched is selected by FIFO_SCHED_EMPTY_REL_EN.
package fifo_sched_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = unsigned'(i + 1);
        end
        return r;
    endfunction

    // Index of the set bit; a zero vector maps to 0.
    function automatic logic [3:0] oh2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  pick,
    output logic            any
);

    always_comb begin
        logic [IDW-1:0] idx;
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(last) + k) % NREQ);
            if (!any && req[idx]) begin
                any  = 1'b1;
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Round-robin burst scheduler sharing one FIFO read port among NREQ consumers.
// Define FIFO_SCHED_EMPTY_REL_EN to release the grant when the FIFO runs empty.
module fifo_rd_sched
    import fifo_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic            rclk,
    input  logic            reset_L,
    input  logic [NREQ-1:0] req,
    input  logic            empty,
    output logic            pop,
    output logic [NREQ-1:0] gnt,
    output logic            rd_valid,
    output logic [IDW-1:0]  rd_id,
    output logic            busy
);

    localparam int unsigned CW = clog2(BURST) + 1;

    logic [0:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rd_valid_q;
    logic [IDW-1:0]  rd_id_q;

    logic [IDW-1:0]  id;
    logic [IDW-1:0]  pick;
    logic            any;
    logic            req_id;
    logic            leave;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

    assign id     = IDW'(oh2idx(16'(gnt_q)));
    assign req_id = req[id];
    assign busy   = (state_q == ST_BURST);
    assign pop    = busy && req_id && !empty;

    // Burst ends on its last allowed pop or when the owner withdraws.
    always_comb begin
        leave = 1'b0;
        if (busy) begin
            if (pop) begin
                leave = (count_q == CW'(BURST - 1));
            end else if (!req_id) begin
                leave = 1'b1;
            end
`ifdef FIFO_SCHED_EMPTY_REL_EN
            else if (empty) begin
                leave = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (any && !empty) begin
                    state_d     = ST_BURST;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    last_d      = pick;
                    count_d     = '0;
                end
            end
            ST_BURST: begin
                if (leave) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                end else if (pop) begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            last_q     <= IDW'(NREQ - 1);
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            count_q    <= count_d;
            rd_valid_q <= pop;
            rd_id_q    <= id;
        end
    end

    assign gnt      = gnt_q;
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Self-checking bench for fifo_rd_sched (BURST=4 instance model-checked, BURST=1 instance pinned).
// Expectations follow FIFO_SCHED_EMPTY_REL_EN when it is defined.
module tb_fifo_rd_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned BURST = 4;
    localparam int unsigned IDW   = 2;

    logic            rclk;
    logic            reset_L;
    logic [NREQ-1:0] req;
    logic            empty;

    logic            pop, rd_valid, busy;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  rd_id;
    logic            pop1, rd_valid1, busy1;
    logic [NREQ-1:0] gnt1;
    logic [IDW-1:0]  rd_id1;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    int words = 1000;
    bit exp_pop_q = 1'b0;

    // Model: current owner (-1 = none), pops used in this burst, last granted.
    int m_owner = -1;
    int m_used  = 0;
    int m_last  = NREQ - 1;
    bit m_rdv   = 1'b0;
    int m_rdid  = 0;

    int exp_g4[7]   = '{1, 1, 1, 1, 0, 2, 2};
    int exp_pop4[7] = '{1, 1, 1, 1, 0, 1, 1};
    int exp_rdv4[7] = '{0, 1, 1, 1, 1, 0, 1};
    int exp_g1[9]   = '{1, 0, 2, 0, 4, 0, 8, 0, 1};

    fifo_rd_sched #(.NREQ(NREQ), .BURST(BURST), .IDW(IDW)) u_dut (
        .rclk     (rclk),
        .reset_L  (reset_L),
        .req      (req),
        .empty    (empty),
        .pop      (pop),
        .gnt      (gnt),
        .rd_valid (rd_valid),
        .rd_id    (rd_id),
        .busy     (busy)
    );

    fifo_rd_sched #(.NREQ(NREQ), .BURST(1), .IDW(IDW)) u_dut1 (
        .rclk     (rclk),
        .reset_L  (reset_L),
        .req      (req),
        .empty    (empty),
        .pop      (pop1),
        .gnt      (gnt1),
        .rd_valid (rd_valid1),
        .rd_id    (rd_id1),
        .busy     (busy1)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit owner_wants(input int o, input logic [NREQ-1:0] r);
        if (o < 0) return 1'b0;
        return r[o];
    endfunction

    function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            m_owner <= -1;
            m_used  <= 0;
            m_last  <= NREQ - 1;
            m_rdv   <= 1'b0;
            m_rdid  <= 0;
        end else begin
            m_rdv  <= owner_wants(m_owner, req) && !empty;
            m_rdid <= (m_owner >= 0) ? m_owner : 0;
            if (m_owner < 0) begin
                if (req != 0 && !empty) begin
                    m_owner <= rr_next(req, m_last);
                    m_last  <= rr_next(req, m_last);
                    m_used  <= 0;
                end
            end else if (owner_wants(m_owner, req) && !empty) begin
                if (m_used + 1 == BURST) m_owner <= -1;
                else m_used <= m_used + 1;
            end else if (!owner_wants(m_owner, req)) begin
                m_owner <= -1;
            end
`ifdef FIFO_SCHED_EMPTY_REL_EN
            else if (empty) begin
                m_owner <= -1;
            end
`endif
        end
    end

    always @(negedge rclk) begin
        if (cmp_en) begin
            check("gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
            check("busy", int'(busy), int'(m_owner >= 0));
            check("pop", int'(pop), int'(owner_wants(m_owner, req) && !empty));
            check("rd_valid", int'(rd_valid), int'(m_rdv));
            if (m_rdv) check("rd_id", int'(rd_id), m_rdid);
            check("pop_while_empty", int'(pop && empty), 0);
        end
        exp_pop_q <= owner_wants(m_owner, req) && !empty;
    end

    // Advance to just after the next rising edge; the FIFO drains on each pop.
    task automatic tick();
        @(posedge rclk);
        #1;
        if (exp_pop_q && words > 0) words--;
        empty = (words == 0);
    endtask

    task automatic set_words(input int n);
        words = n;
        empty = (n == 0);
    endtask

    task automatic reset_dut();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    initial begin
        int nv;
        int c0, c3, cx;
        reset_L = 1'b0;
        req     = '0;
        empty   = 1'b0;

        // Reset state, then round robin from requester 0 with full bursts.
        req = 4'b1111;
        tick();
        tick();
        cmp_en = 1'b1;
        @(negedge rclk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_pop", int'(pop), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        tick();
        set_words(1000);
        reset_L = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            @(negedge rclk);
            if (i < 7) begin
                check("rr4_gnt", int'(gnt), exp_g4[i]);
                check("rr4_pop", int'(pop), exp_pop4[i]);
                check("rr4_rd_valid", int'(rd_valid), exp_rdv4[i]);
            end
            check("b1_gnt", int'(gnt1), exp_g1[i]);
            check("b1_pop", int'(pop1), int'(exp_g1[i] != 0));
            if (i == 0) check("b1_busy", int'(busy1), 1);
            if (i == 1) begin
                check("b1_rd_valid", int'(rd_valid1), 1);
                check("b1_rd_id", int'(rd_id1), 0);
                check("b1_busy_bubble", int'(busy1), 0);
            end
        end

        // Single requester, two words in the FIFO, then it runs dry.
        req = 4'b0100;
        reset_dut();
        set_words(2);
        tick(); @(negedge rclk);
        check("dry_first_gnt", int'(gnt), 4);
        tick(); @(negedge rclk);
        tick(); @(negedge rclk);
        check("dry_gnt_held", int'(gnt), 4);
        check("dry_no_pop", int'(pop), 0);
        check("dry_rd_valid", int'(rd_valid), 1);
        check("dry_rd_id", int'(rd_id), 2);
        tick(); @(negedge rclk);
`ifdef FIFO_SCHED_EMPTY_REL_EN
        check("dry_gnt_after", int'(gnt), 0);
`else
        check("dry_gnt_after", int'(gnt), 4);
`endif
        tick();
        set_words(3);
        repeat (10) tick();
        req = '0;
        repeat (3) tick();

        // Requester 1 withdraws after two pops.
        req = 4'b0010;
        reset_dut();
        set_words(1000);
        nv = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 3) req = '0;
            @(negedge rclk);
            if (i == 3) check("drop_no_pop", int'(pop), 0);
            if (i == 4) check("drop_gnt", int'(gnt), 0);
            if (rd_valid) begin
                nv++;
                check("drop_rd_id", int'(rd_id), 1);
            end
        end
        check("drop_rd_valid_count", nv, 2);

        // Two requesters alternating under continuous data.
        req = 4'b1001;
        reset_dut();
        set_words(1000);
        tick(); @(negedge rclk);
        check("alt_first_gnt", int'(gnt), 1);
        c0 = 0; c3 = 0; cx = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge rclk);
            if (rd_valid) begin
                if (rd_id == 2'd0) c0++;
                else if (rd_id == 2'd3) c3++;
                else cx++;
            end
        end
        check("alt_pops_req0", c0, 16);
        check("alt_pops_req3", c3, 16);
        check("alt_pops_other", cx, 0);

        // Asynchronous reset in the middle of a burst.
        req = 4'b1111;
        reset_dut();
        set_words(1000);
        tick(); tick(); tick();
        @(negedge rclk);
        check("mid_rd_valid_before", int'(rd_valid), 1);
        #2;
        reset_L = 1'b0;
        #1;
        check("async_pop", int'(pop), 0);
        check("async_gnt", int'(gnt), 0);
        check("async_rd_valid", int'(rd_valid), 0);
        check("async_busy", int'(busy), 0);
        req = 4'b0110;
        tick();
        tick();
        reset_L = 1'b1;
        tick(); @(negedge rclk);
        check("post_rst_gnt", int'(gnt), 2);

        req = '0;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
